// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the program-ROM arbiter.
// The requester_e values double as bit indices into the one-hot grant vector.
package rom_arb_pkg;

    typedef enum logic [0:0] {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } requester_e;

    localparam int ROM_ADDR_W   = 16;
    localparam int ROM_DATA_W   = 16;
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/rom_arb_if.sv
// One requester port of the ROM arbiter: req/gnt handshake plus registered response.
// master = requester side, slave = arbiter side.
interface rom_arb_if
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, input  gnt, rvalid, rdata);
    modport slave  (input  req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/rom_arb_policy.sv
// Grant policy for the ROM arbiter: fixed fetch priority with a load starvation guard,
// or round-robin on contention when ROM_ARB_ROUND_ROBIN_EN is defined.
module rom_arb_policy
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic       load_req,
    output logic [1:0] gnt_oh
);

`ifdef ROM_ARB_ROUND_ROBIN_EN

    requester_e last_gnt;

    always_comb begin
        gnt_oh = '0;
        if (rst_n) begin
            if (fetch_req && load_req) begin
                if (last_gnt == REQ_LOAD) gnt_oh[REQ_FETCH] = 1'b1;
                else                      gnt_oh[REQ_LOAD]  = 1'b1;
            end else if (fetch_req) begin
                gnt_oh[REQ_FETCH] = 1'b1;
            end else if (load_req) begin
                gnt_oh[REQ_LOAD] = 1'b1;
            end
        end
    end

    // Reset to LOAD so the first contended grant goes to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= REQ_LOAD;
        end else if (gnt_oh[REQ_LOAD]) begin
            last_gnt <= REQ_LOAD;
        end else if (gnt_oh[REQ_FETCH]) begin
            last_gnt <= REQ_FETCH;
        end
    end

`else

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_cnt_nxt;
    logic                    force_load;

    assign force_load = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

    always_comb begin
        gnt_oh         = '0;
        starve_cnt_nxt = starve_cnt;
        if (rst_n) begin
            if (fetch_req && !(load_req && force_load)) gnt_oh[REQ_FETCH] = 1'b1;
            else if (load_req)                          gnt_oh[REQ_LOAD]  = 1'b1;
        end
        // Count only consecutive denied cycles of a pending load; saturate at the limit.
        if (!load_req || gnt_oh[REQ_LOAD]) begin
            starve_cnt_nxt = '0;
        end else if (!force_load) begin
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else        starve_cnt <= starve_cnt_nxt;
    end

`endif

endmodule

// File: rtl/rom_arbiter.sv
// Shares the combinational program-ROM read port between instruction fetch and data load.
// Policy selected by ROM_ARB_ROUND_ROBIN_EN (see rom_arb_policy); responses arrive one cycle after grant.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int STARVE_MAX = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    rom_arb_if.slave          fetch,
    rom_arb_if.slave          load,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    logic [1:0]        gnt_oh;
    logic              fetch_rvalid_q;
    logic              load_rvalid_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic [DATA_W-1:0] load_rdata_q;

    rom_arb_policy #(
        .STARVE_MAX (STARVE_MAX)
    ) u_policy (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch.req),
        .load_req  (load.req),
        .gnt_oh    (gnt_oh)
    );

    assign fetch.gnt = gnt_oh[REQ_FETCH];
    assign load.gnt  = gnt_oh[REQ_LOAD];

    always_comb begin
        rom_addr = '0;
        if (gnt_oh[REQ_FETCH])     rom_addr = fetch.addr;
        else if (gnt_oh[REQ_LOAD]) rom_addr = load.addr;
    end

    // rdata holds between grants; rvalid is a one-cycle echo of the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_rvalid_q <= 1'b0;
            load_rvalid_q  <= 1'b0;
            fetch_rdata_q  <= '0;
            load_rdata_q   <= '0;
        end else begin
            fetch_rvalid_q <= gnt_oh[REQ_FETCH];
            load_rvalid_q  <= gnt_oh[REQ_LOAD];
            if (gnt_oh[REQ_FETCH]) fetch_rdata_q <= rom_data;
            if (gnt_oh[REQ_LOAD])  load_rdata_q  <= rom_data;
        end
    end

    assign fetch.rvalid = fetch_rvalid_q;
    assign fetch.rdata  = fetch_rdata_q;
    assign load.rvalid  = load_rvalid_q;
    assign load.rdata   = load_rdata_q;

endmodule
